// File: rtl/shared_fifo_arbiter_pkg.sv
// Shared widths and helpers for the shared_fifo_arbiter block.
// A slot entry is packed as {index, payload}; widths derive from the functions below.
package shared_fifo_arbiter_pkg;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span = 1;
        while (span < value) begin
            span = span * 2;
            result++;
        end
        return result;
    endfunction

    // Origin-index width, at least one bit.
    function automatic int idx_w(input int num_inputs);
        return (clog2(num_inputs) > 1) ? clog2(num_inputs) : 1;
    endfunction

    // Slot pointer width, at least one bit.
    function automatic int ptr_w(input int num_slots);
        return (clog2(num_slots) > 1) ? clog2(num_slots) : 1;
    endfunction

    // Occupancy width: must hold 0..num_slots inclusive.
    function automatic int cnt_w(input int num_slots);
        return clog2(num_slots + 1);
    endfunction

    // Width of one stored {index, payload} entry.
    function automatic int slot_w(input int index_w, input int data_w);
        return index_w + data_w;
    endfunction

endpackage

// File: rtl/shared_fifo_arbiter_if.sv
// Handshake bundle between the producers/consumer and shared_fifo_arbiter.
// slave is the arbiter side, master the environment side.
interface shared_fifo_arbiter_if
    import shared_fifo_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_TYPE  = 32,
    parameter int IDX_W      = idx_w(NUM_INPUTS)
);

    logic [NUM_INPUTS*DATA_TYPE-1:0] ins;
    logic [NUM_INPUTS-1:0]           ins_valid;
    logic [NUM_INPUTS-1:0]           ins_ready;
    logic [DATA_TYPE-1:0]            outs;
    logic [IDX_W-1:0]                outs_index;
    logic                            outs_valid;
    logic                            outs_ready;

    modport master (
        output ins,
        output ins_valid,
        output outs_ready,
        input  ins_ready,
        input  outs,
        input  outs_index,
        input  outs_valid
    );

    modport slave (
        input  ins,
        input  ins_valid,
        input  outs_ready,
        output ins_ready,
        output outs,
        output outs_index,
        output outs_valid
    );

endinterface

// File: rtl/shared_fifo_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr.
// Produces a one-hot grant, its encoded index and an any-grant flag.
module rr_arbiter #(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = 1
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IDX_W-1:0]      rr_ptr,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  grant_valid
);

    int pos;

    // Walk the channels from rr_ptr with wrap, keep the first request seen.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = 0;
        for (int off = 0; off < NUM_INPUTS; off++) begin
            pos = (int'(rr_ptr) + off) % NUM_INPUTS;
            if (!grant_valid && req[pos]) begin
                grant_valid = 1'b1;
                grant[pos]  = 1'b1;
                grant_idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/shared_fifo_arbiter.sv
// Round-robin front end sharing one circular FIFO among NUM_INPUTS producers.
// Optional macro SHARED_FIFO_ARBITER_OCCUPANCY_EN exposes the registered count.
module shared_fifo_arbiter
    import shared_fifo_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_TYPE  = 32,
    parameter int NUM_SLOTS  = 4
) (
    input logic clk,
    input logic rst,
    shared_fifo_arbiter_if.slave bus
`ifdef SHARED_FIFO_ARBITER_OCCUPANCY_EN
    ,
    output logic [cnt_w(NUM_SLOTS)-1:0] occupancy
`endif
);

    localparam int IDX_W = idx_w(NUM_INPUTS);
    localparam int PTR_W = ptr_w(NUM_SLOTS);
    localparam int CNT_W = cnt_w(NUM_SLOTS);

    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);
    localparam logic [IDX_W-1:0] LAST_IN   = IDX_W'(NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(NUM_SLOTS);

    typedef struct packed {
        logic [IDX_W-1:0]     index;
        logic [DATA_TYPE-1:0] payload;
    } slot_t;

    slot_t                 mem [NUM_SLOTS];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [IDX_W-1:0]      rr_ptr;

    logic [NUM_INPUTS-1:0] grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [DATA_TYPE-1:0]  grant_data;
    logic                  can_accept;
    logic                  push;
    logic                  pop;
    slot_t                 head;

    rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_rr_arbiter (
        .req         (bus.ins_valid),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Handshakes are masked while reset is held so none completes on a reset edge.
    // Readiness depends only on registered count, never on outs_ready.
    assign can_accept    = rst && (count < FULL);
    assign bus.ins_ready = can_accept ? grant : '0;
    assign push          = grant_valid && can_accept;
    assign grant_data    = bus.ins[int'(grant_idx)*DATA_TYPE +: DATA_TYPE];

    assign bus.outs_valid = rst && (count != '0);
    assign pop            = bus.outs_valid && bus.outs_ready;

    assign head           = mem[rd_ptr];
    assign bus.outs       = head.payload;
    assign bus.outs_index = head.index;

`ifdef SHARED_FIFO_ARBITER_OCCUPANCY_EN
    assign occupancy = count;
`endif

    // Slot storage: write the granted token tagged with its channel.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{index: grant_idx, payload: grant_data};
        end
    end

    // Pointers, occupancy and round-robin state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PTR_W'(1);
                rr_ptr <= (grant_idx == LAST_IN) ? '0 : grant_idx + IDX_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_shared_fifo_arbiter.sv
// Randomised scoreboard bench for shared_fifo_arbiter (3 inputs, 4 slots).
// Stimulus predicts grants from a queue model; a monitor checks every output.
module tb_shared_fifo_arbiter;

    localparam int NI = 3;
    localparam int DW = 32;
    localparam int NS = 4;

    typedef struct packed {
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } tok_t;

    logic clk;
    logic rst;

    shared_fifo_arbiter_if #(.NUM_INPUTS(NI), .DATA_TYPE(DW), .IDX_W(2)) bus ();

`ifdef SHARED_FIFO_ARBITER_OCCUPANCY_EN
    logic [2:0] occ;
`endif

    shared_fifo_arbiter #(
        .NUM_INPUTS (NI),
        .DATA_TYPE  (DW),
        .NUM_SLOTS  (NS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SHARED_FIFO_ARBITER_OCCUPANCY_EN
        ,
        .occupancy (occ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    tok_t          expq [$];
    int            mcnt = 0;
    int            mrr  = 0;
    logic [DW-1:0] pay [NI];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int rr_pick(input logic [NI-1:0] v, input int from);
        for (int k = 0; k < NI; k++) begin
            if (v[(from + k) % NI]) return (from + k) % NI;
        end
        return -1;
    endfunction

    // One clock of stimulus; g returns the channel the model expects accepted, or -1.
    task automatic step(input logic r, input logic [NI-1:0] v, input logic ordy, output int g);
        logic [NI-1:0] exp_ready;
        logic          exp_valid;
        int            pick;
        @(negedge clk);
        rst = r;
        bus.ins_valid  = v;
        bus.outs_ready = ordy;
        for (int i = 0; i < NI; i++) bus.ins[i*DW +: DW] = pay[i];
        #2;
        exp_valid = r && (mcnt > 0);
        pick      = rr_pick(v, mrr);
        exp_ready = '0;
        if (r && pick >= 0 && mcnt < NS) exp_ready[pick] = 1'b1;
        check("ins_ready", 64'(bus.ins_ready), 64'(exp_ready));
        check("outs_valid", 64'(bus.outs_valid), 64'(exp_valid));
`ifdef SHARED_FIFO_ARBITER_OCCUPANCY_EN
        if (r) check("occupancy", 64'(occ), 64'(mcnt));
`endif
        g = -1;
        if (!r) begin
            mcnt = 0;
            mrr  = 0;
            expq.delete();
        end else begin
            if (exp_ready != '0) begin
                g = pick;
                expq.push_back('{idx: 2'(pick), data: pay[pick]});
                mrr = (pick + 1) % NI;
                mcnt++;
            end
            if (exp_valid && ordy) mcnt--;
        end
    endtask

    task automatic rand_pay();
        for (int i = 0; i < NI; i++) pay[i] = $urandom;
    endtask

    // Output monitor: head must equal the oldest expected token whenever valid.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (bus.outs_valid) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    $display("FAIL outs_unexpected: got %0h expected none at %0t", bus.outs, $time);
                end else begin
                    check("outs", 64'(bus.outs), 64'(expq[0].data));
                    check("outs_index", 64'(bus.outs_index), 64'(expq[0].idx));
                    if (bus.outs_ready) void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        int g;
        int k;
        int n;
        rst = 1'b0;
        bus.ins = '0;
        bus.ins_valid = '0;
        bus.outs_ready = 1'b0;
        rand_pay();

        // Reset held with all inputs requesting.
        for (int i = 0; i < 3; i++) step(1'b0, 3'b111, 1'b1, g);

        // Round-robin from channel 0 with everything valid.
        for (int i = 0; i < 6; i++) begin
            rand_pay();
            step(1'b1, 3'b111, 1'b1, g);
            check("rr_order", 64'(bus.ins_ready), 64'(3'b001 << (i % NI)));
        end
        for (int i = 0; i < 4; i++) step(1'b1, 3'b000, 1'b1, g);

        // Fill to full from channel 1, then drain in order.
        k = 0;
        for (int i = 0; i < 6; i++) begin
            pay[1] = 32'hA0 + 32'(k);
            step(1'b1, 3'b010, 1'b0, g);
            if (g == 1) k++;
        end
        check("full_accepts", 64'(k), 64'd4);
        for (int i = 0; i < 8; i++) begin
            pay[1] = 32'hA0 + 32'(k);
            step(1'b1, 3'b010, 1'b1, g);
            if (g == 1) k++;
        end
        for (int i = 0; i < 8; i++) step(1'b1, 3'b000, 1'b1, g);

        // Hold two tokens, then push and pop every cycle with pointer wrap.
        n = 0;
        while (mcnt < 2 && n < 20) begin
            rand_pay();
            step(1'b1, 3'b001, 1'b0, g);
            n++;
        end
        check("prefill_two", 64'(mcnt), 64'd2);
        for (int i = 0; i < 200; i++) begin
            rand_pay();
            step(1'b1, 3'b111, 1'b1, g);
        end

        // Random requests against random backpressure.
        for (int i = 0; i < 300; i++) begin
            rand_pay();
            step(1'b1, 3'($urandom), 1'($urandom), g);
        end

        // Reset at count 3 must discard the stored tokens.
        for (int i = 0; i < 8; i++) step(1'b1, 3'b000, 1'b1, g);
        n = 0;
        while (mcnt < 3 && n < 20) begin
            rand_pay();
            step(1'b1, 3'($urandom), 1'b0, g);
            n++;
        end
        check("prefill_three", 64'(mcnt), 64'd3);
        step(1'b0, 3'b111, 1'b0, g);
        pay[2] = 32'h0000_0055;
        step(1'b1, 3'b100, 1'b0, g);
        check("post_reset_accept", 64'(g), 64'd2);
        for (int i = 0; i < 6; i++) step(1'b1, 3'b000, 1'b1, g);

        check("drained", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
